// File: rtl/stack_control_n.sv
// stack_control_n: N_SP memory-mapped stack pointers, 0xC000 window remapped to {SP[sel], a[7:0]}; writes land at clk edge, reads/strobes combinational, no backpressure.
// Optional STACK_CONTROL_GUARD_EN: saturating INC/DEC with OVF/UNF flags, STATUS at 0xB and an irq output.
module stack_control_n #(
   parameter int         N_SP   = 2,
   parameter int         SP_W   = 8,
   parameter logic [5:0] CTL_HI = 6'h3F,
   parameter logic [3:0] WIN_HI = 4'hC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       a,
   input  logic [7:0]        d,
   input  logic              n_we,
   input  logic              n_oe,
   output logic [7:0]        q,
   output logic              n_oe_q,
   output logic [SP_W+7:0]   bank_a,
   output logic              n_oe_bank,
   output logic              n_we_bank
`ifdef STACK_CONTROL_GUARD_EN
   ,
   output logic              irq
`endif
);

   localparam int SEL_W = (N_SP > 1) ? $clog2(N_SP) : 1;

   logic [SP_W-1:0]  sp [N_SP];
   logic             ena;
   logic             reg_hit;
   logic             win_hit;
   logic             wr;
   logic [3:0]       off;
   logic [SEL_W-1:0] sel;
   logic             sel_ok;
   logic [SP_W-1:0]  sp_sel;
   logic             rd_map;
   logic [7:0]       rd_dat;
   logic             unused_a;

   assign reg_hit = (a[15:10] == CTL_HI) && (a[9:8] == 2'b00);
   assign win_hit = (a[15:12] == WIN_HI);
   assign off     = a[3:0];
   assign wr      = reg_hit && !n_we;
   assign unused_a = ^a[11:10];

   generate
      if (N_SP > 1) begin : g_sel
         assign sel = a[11 -: SEL_W];
      end else begin : g_sel0
         assign sel = '0;
      end
   endgenerate

   assign sel_ok = (int'(sel) < N_SP);

`ifdef STACK_CONTROL_GUARD_EN
   logic [N_SP-1:0] ovf;
   logic [N_SP-1:0] unf;
   logic [7:0]      ovf_ext;
   logic [7:0]      unf_ext;
   logic [7:0]      ovf_clr8;
   logic [7:0]      unf_clr8;

   assign ovf_clr8 = {4'h0, d[3:0]};
   assign unf_clr8 = {4'h0, d[7:4]};
   assign irq      = |{ovf, unf};

   always_comb begin
      ovf_ext = '0;
      unf_ext = '0;
      ovf_ext[N_SP-1:0] = ovf;
      unf_ext[N_SP-1:0] = unf;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_SP; i++) sp[i] <= '0;
         ena <= 1'b0;
`ifdef STACK_CONTROL_GUARD_EN
         ovf <= '0;
         unf <= '0;
`endif
      end else begin
         if (wr && off == 4'hA) ena <= d[0];
`ifdef STACK_CONTROL_GUARD_EN
         // Clears are issued first so a same-cycle set below overrides them.
         if (wr && off == 4'hB) begin
            ovf <= ovf & ~ovf_clr8[N_SP-1:0];
            unf <= unf & ~unf_clr8[N_SP-1:0];
         end
`endif
         for (int i = 0; i < N_SP; i++) begin
            if (wr && off == 4'(i)) begin
               sp[i] <= d[SP_W-1:0];
            end else if (wr && off == 4'h8 && d[i]) begin
`ifdef STACK_CONTROL_GUARD_EN
               if (sp[i] == {SP_W{1'b1}}) ovf[i] <= 1'b1;
               else                       sp[i] <= sp[i] + SP_W'(1);
`else
               sp[i] <= sp[i] + SP_W'(1);
`endif
            end else if (wr && off == 4'h9 && d[i]) begin
`ifdef STACK_CONTROL_GUARD_EN
               if (sp[i] == '0) unf[i] <= 1'b1;
               else             sp[i] <= sp[i] - SP_W'(1);
`else
               sp[i] <= sp[i] - SP_W'(1);
`endif
            end
         end
      end
   end

   always_comb begin
      rd_map = 1'b0;
      rd_dat = 8'h00;
      for (int i = 0; i < N_SP; i++) begin
         if (off == 4'(i)) begin
            rd_map = 1'b1;
            rd_dat = 8'(sp[i]);
         end
      end
      if (off == 4'hA) begin
         rd_map = 1'b1;
         rd_dat = {7'h00, ena};
      end
`ifdef STACK_CONTROL_GUARD_EN
      if (off == 4'hB) begin
         rd_map = 1'b1;
         rd_dat = {unf_ext[3:0], ovf_ext[3:0]};
      end
`endif
   end

   assign n_oe_q = !(reg_hit && !n_oe && rd_map);
   assign q      = n_oe_q ? 8'h00 : rd_dat;

   always_comb begin
      sp_sel = '0;
      for (int i = 0; i < N_SP; i++) begin
         if (sel == SEL_W'(i)) sp_sel = sp[i];
      end
   end

   assign bank_a    = {sp_sel, a[7:0]};
   assign n_oe_bank = !(ena && win_hit && sel_ok && !n_oe);
   assign n_we_bank = !(ena && win_hit && sel_ok && !n_we);

endmodule

// File: tb/tb_stack_control_n.sv
// Directed bench for stack_control_n: default N_SP=2 instance plus an N_SP=3 instance sharing the CPU bus.
module tb_stack_control_n;

   logic        clk;
   logic        rst;
   logic [15:0] a;
   logic [7:0]  d;
   logic        n_we;
   logic        n_oe;
   logic [7:0]  q, q3;
   logic        n_oe_q, n_oe_q3;
   logic [15:0] bank_a, bank_a3;
   logic        n_oe_bank, n_oe_bank3;
   logic        n_we_bank, n_we_bank3;
`ifdef STACK_CONTROL_GUARD_EN
   logic        irq, irq3;
`endif
   int total;
   int bad;

   stack_control_n u_dut (
      .clk(clk), .rst(rst), .a(a), .d(d), .n_we(n_we), .n_oe(n_oe),
      .q(q), .n_oe_q(n_oe_q), .bank_a(bank_a), .n_oe_bank(n_oe_bank), .n_we_bank(n_we_bank)
`ifdef STACK_CONTROL_GUARD_EN
      , .irq(irq)
`endif
   );

   stack_control_n #(.N_SP(3)) u_dut3 (
      .clk(clk), .rst(rst), .a(a), .d(d), .n_we(n_we), .n_oe(n_oe),
      .q(q3), .n_oe_q(n_oe_q3), .bank_a(bank_a3), .n_oe_bank(n_oe_bank3), .n_we_bank(n_we_bank3)
`ifdef STACK_CONTROL_GUARD_EN
      , .irq(irq3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
      @(negedge clk);
      a = addr; d = data; n_we = 1'b0;
      @(negedge clk);
      n_we = 1'b1;
   endtask

   // Drives a read at the falling edge and leaves the strobe low for sampling.
   task automatic rd_start(input logic [15:0] addr);
      @(negedge clk);
      a = addr; n_oe = 1'b0;
      #1;
   endtask

   task automatic rd_end();
      n_oe = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; a = 16'hFC00; d = 8'h00; n_we = 1'b1; n_oe = 1'b0;
      #12;
      total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h want=00", q); end
      a = 16'hFC02; #1;
      total++; if (n_oe_q !== 1'b1) begin bad++; $display("FAIL reset_unmapped_oe got=%b want=1", n_oe_q); end
      a = 16'hC005; #1;
      total++; if (n_oe_bank !== 1'b1) begin bad++; $display("FAIL reset_oe_bank got=%b want=1", n_oe_bank); end
      total++; if (n_we_bank !== 1'b1) begin bad++; $display("FAIL reset_we_bank got=%b want=1", n_we_bank); end
      n_oe = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_sp_rw();
      wr_reg(16'hFC00, 8'h12);
      wr_reg(16'hFC01, 8'h34);
      rd_start(16'hFC00);
      total++; if (q !== 8'h12) begin bad++; $display("FAIL sp0_read got=%h want=12", q); end
      total++; if (n_oe_q !== 1'b0) begin bad++; $display("FAIL sp0_oe got=%b want=0", n_oe_q); end
      rd_end();
      rd_start(16'hFC01);
      total++; if (q !== 8'h34) begin bad++; $display("FAIL sp1_read got=%h want=34", q); end
      rd_end();
   endtask

   task automatic test_incdec();
      wr_reg(16'hFC08, 8'h03);
      rd_start(16'hFC00);
      total++; if (q !== 8'h13) begin bad++; $display("FAIL inc_sp0 got=%h want=13", q); end
      a = 16'hFC01; #1;
      total++; if (q !== 8'h35) begin bad++; $display("FAIL inc_sp1 got=%h want=35", q); end
      a = 16'hFC08; #1;
      total++; if (n_oe_q !== 1'b1) begin bad++; $display("FAIL inc_wo_oe got=%b want=1", n_oe_q); end
      rd_end();
      wr_reg(16'hFC09, 8'h02);
      rd_start(16'hFC01);
      total++; if (q !== 8'h34) begin bad++; $display("FAIL dec_sp1 got=%h want=34", q); end
      a = 16'hFC00; #1;
      total++; if (q !== 8'h13) begin bad++; $display("FAIL dec_sp0_kept got=%h want=13", q); end
      rd_end();
   endtask

   task automatic test_window();
      rd_start(16'hC105);
      total++; if (n_oe_bank !== 1'b1) begin bad++; $display("FAIL win_disabled got=%b want=1", n_oe_bank); end
      a = 16'hFC0A; #1;
      total++; if (q !== 8'h00) begin bad++; $display("FAIL ctrl_off got=%h want=00", q); end
      rd_end();
      wr_reg(16'hFC0A, 8'h01);
      rd_start(16'hFC0A);
      total++; if (q !== 8'h01) begin bad++; $display("FAIL ctrl_on got=%h want=01", q); end
      a = 16'hC805; #1;
      total++; if (n_oe_bank !== 1'b0) begin bad++; $display("FAIL win_oe got=%b want=0", n_oe_bank); end
      total++; if (bank_a !== 16'h3405) begin bad++; $display("FAIL win_bank_a got=%h want=3405", bank_a); end
      total++; if (n_we_bank !== 1'b1) begin bad++; $display("FAIL win_we_idle got=%b want=1", n_we_bank); end
      a = 16'hC1AB; #1;
      total++; if (bank_a !== 16'h13AB) begin bad++; $display("FAIL win_sel0 got=%h want=13AB", bank_a); end
      rd_end();
      @(negedge clk);
      a = 16'hC805; d = 8'h77; n_we = 1'b0; #1;
      total++; if (n_we_bank !== 1'b0) begin bad++; $display("FAIL win_we got=%b want=0", n_we_bank); end
      @(negedge clk); n_we = 1'b1;
      rd_start(16'hFC01);
      total++; if (q !== 8'h34) begin bad++; $display("FAIL win_write_nostate got=%h want=34", q); end
      rd_end();
   endtask

   task automatic test_unmapped();
      rd_start(16'hFC02);
      total++; if (n_oe_q !== 1'b1 || q !== 8'h00) begin bad++; $display("FAIL unmap_sp2 oe=%b q=%h want oe=1 q=00", n_oe_q, q); end
      total++; if (n_oe_q3 !== 1'b0 || q3 !== 8'h00) begin bad++; $display("FAIL n3_sp2 oe=%b q=%h want oe=0 q=00", n_oe_q3, q3); end
      a = 16'hFC03; #1;
      total++; if (n_oe_q3 !== 1'b1 || q3 !== 8'h00) begin bad++; $display("FAIL n3_sp3 oe=%b q=%h want oe=1 q=00", n_oe_q3, q3); end
      a = 16'hFC0C; #1;
      total++; if (n_oe_q !== 1'b1) begin bad++; $display("FAIL unmap_c got=%b want=1", n_oe_q); end
      a = 16'hFD00; #1;
      total++; if (n_oe_q !== 1'b1) begin bad++; $display("FAIL a98_nonzero got=%b want=1", n_oe_q); end
`ifndef STACK_CONTROL_GUARD_EN
      a = 16'hFC0B; #1;
      total++; if (n_oe_q !== 1'b1) begin bad++; $display("FAIL status_absent got=%b want=1", n_oe_q); end
`endif
      a = 16'hCC00; #1;
      total++; if (n_oe_bank3 !== 1'b1) begin bad++; $display("FAIL n3_sel3_oe got=%b want=1", n_oe_bank3); end
      total++; if (bank_a3 !== 16'h0000) begin bad++; $display("FAIL n3_sel3_a got=%h want=0000", bank_a3); end
      a = 16'hC405; #1;
      total++; if (n_oe_bank3 !== 1'b0 || bank_a3 !== 16'h3405) begin bad++; $display("FAIL n3_sel1 oe=%b a=%h want oe=0 a=3405", n_oe_bank3, bank_a3); end
      rd_end();
   endtask

   task automatic test_rst_mid();
      @(posedge clk);
      #3;
      rst = 1'b1; a = 16'hFC0A; n_oe = 1'b0; #1;
      total++; if (q !== 8'h00 || n_oe_q !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl q=%h oe=%b want q=00 oe=0", q, n_oe_q); end
      a = 16'hFC01; #1;
      total++; if (q !== 8'h00) begin bad++; $display("FAIL rst_mid_sp1 got=%h want=00", q); end
      a = 16'hC805; #1;
      total++; if (n_oe_bank !== 1'b1) begin bad++; $display("FAIL rst_mid_bank got=%b want=1", n_oe_bank); end
      n_oe = 1'b1;
      // Write held across an edge while reset is asserted must be dropped.
      a = 16'hFC00; d = 8'hAA; n_we = 1'b0;
      @(negedge clk); n_we = 1'b1; rst = 1'b0;
      rd_start(16'hFC00);
      total++; if (q !== 8'h00) begin bad++; $display("FAIL rst_write_dropped got=%h want=00", q); end
      rd_end();
   endtask

   task automatic test_wrap();
      wr_reg(16'hFC00, 8'hFF);
      wr_reg(16'hFC08, 8'h01);
      rd_start(16'hFC00);
`ifdef STACK_CONTROL_GUARD_EN
      total++; if (q !== 8'hFF) begin bad++; $display("FAIL inc_sat got=%h want=FF", q); end
      a = 16'hFC0B; #1;
      total++; if (q !== 8'h01) begin bad++; $display("FAIL status_ovf got=%h want=01", q); end
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b want=1", irq); end
      rd_end();
      wr_reg(16'hFC0B, 8'h01);
      rd_start(16'hFC0B);
      total++; if (q !== 8'h00) begin bad++; $display("FAIL status_clr got=%h want=00", q); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b want=0", irq); end
      rd_end();
      wr_reg(16'hFC09, 8'h02);
      rd_start(16'hFC01);
      total++; if (q !== 8'h00) begin bad++; $display("FAIL dec_sat got=%h want=00", q); end
      a = 16'hFC0B; #1;
      total++; if (q !== 8'h20) begin bad++; $display("FAIL status_unf got=%h want=20", q); end
      rd_end();
`else
      total++; if (q !== 8'h00) begin bad++; $display("FAIL inc_wrap got=%h want=00", q); end
      rd_end();
      wr_reg(16'hFC09, 8'h02);
      rd_start(16'hFC01);
      total++; if (q !== 8'hFF) begin bad++; $display("FAIL dec_wrap got=%h want=FF", q); end
      rd_end();
`endif
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_sp_rw();
      test_incdec();
      test_window();
      test_unmapped();
      test_rst_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
